gpr_dump: RTL and testbench
===========================

# gpr_dump

Post-halt register readback unit for the pipeline CPU. When the CPU halts, it walks the general-purpose register file through a dedicated read port. It streams each register value out over a valid/ready interface, tagged with its index. It is the read-side counterpart of register preloading: hardware, not hierarchical testbench access, extracts the final architectural state.

## Interface
Parameters:
- `DATA_W`, 32, register/data width
- `ADDR_W`, 5, register index width
- `FIRST_REG`, 1, first index dumped
- `LAST_REG`, 31, last index dumped; requires `FIRST_REG <= LAST_REG < 2**ADDR_W`

Ports:
- `clock`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `halt`  in  1  CPU halted level; a 0→1 edge starts a dump
- `rd_addr`  out  ADDR_W  register file read address
- `rd_data`  in  DATA_W  register file read data, combinational from `rd_addr`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  DATA_W  register value
- `out_index`  out  ADDR_W  register index of `out_data`
- `out_last`  out  1  final word of dump
- `busy`  out  1  dump in progress
- `done`  out  1  dump complete, held until `halt` falls

## Operation
- `halt_q` registers `halt`. Start event: `halt & ~halt_q`, honoured only in IDLE; start edges in other states are dropped.
- Index counter `idx`, ADDR_W bits. `rd_addr = idx` at all times.
- States:
  - IDLE: on start, `idx <= FIRST_REG`, go to READ.
  - READ: `out_data <= rd_data`, `out_index <= idx`, go to SEND.
  - SEND: `out_valid = 1`. On `out_ready`: if `idx == LAST_REG`, go to DONE; else `idx <= idx + 1` and go to READ. Without `out_ready`, hold; `out_data`/`out_index`/`out_last` stay stable.
  - DONE: `done = 1`. When `halt == 0`, go to IDLE.
- Output encodings:
  - `busy = 1` in READ and SEND.
  - `out_last = 1` in SEND when `idx == LAST_REG`.
- `idx` never exceeds `LAST_REG`, so there is no wrap.
- If `halt` falls mid-dump, the dump still completes. DONE is then visited for exactly one cycle before IDLE.
- Reset at any time: state IDLE immediately, with no partial word completed.
- Reset values:
  - `idx = FIRST_REG`, `halt_q = 0`
  - `out_valid = 0`, `out_data = 0`, `out_index = 0`, `out_last = 0`, `busy = 0`, `done = 0`, `rd_addr = FIRST_REG`

## Timing
- Edge C: `halt` is sampled high with `halt_q` low. READ occupies cycle C+1, and the first `out_valid` is high in cycle C+2.
- Each word costs 2 cycles (READ + SEND) with `out_ready` held high. Each stall cycle in SEND adds 1 cycle.
- A full default dump of 31 words takes 62 cycles from start to DONE with `out_ready = 1`. `done` rises in cycle C+63.
- `rd_data` is sampled at the end of READ only. Register file writes during SEND are not reflected until that index is read.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready` or `rd_data` to any output.

## Configuration
- `GPR_DUMP_CHECKSUM_EN` defined:
  - After the `LAST_REG` word is accepted, an extra CHECK state emits one more word.
  - That word carries `out_data` = XOR of all dumped values, `out_index = 0`, `out_last = 1`.
  - `out_last` is then 0 on the `LAST_REG` word.
  - The running XOR accumulator clears on start and resets to 0.
  - Default dump length is 32 words, 64 cycles.
- Undefined: no CHECK state, no accumulator, behaviour as described above.

## Test plan
- GPR[i] = i, `out_ready = 1`, single `halt` pulse held high:
  - 31 words are emitted with `out_index` 1..31 and `out_data` 1..31.
  - `out_last` is high only on index 31, and `done` is high at C+63.
- Same preload, `out_ready` low for 3 cycles on index 5:
  - `out_data = 5` and `out_index = 5` are held stable for those 3 cycles.
  - No word is skipped or duplicated, and the total is 65 cycles.
- Reset asserted while `out_index = 10` is pending:
  - All outputs go to reset values asynchronously.
  - A new `halt` edge after release restarts the dump from index 1.
- `halt` drops while index 20 is pending:
  - The dump finishes through index 31.
  - `done` is high for one cycle, then the unit is in IDLE.
  - A second `halt` edge produces a full new dump.
- `GPR_DUMP_CHECKSUM_EN` with GPR[i] = i:
  - A 32nd word is emitted with `out_data = 0x00000000`, `out_index = 0`, `out_last = 1`.
  - With GPR[1] changed to 0xAA, the checksum word is `0x000000AB`.

Source files
------------

// File: rtl/gpr_dump.sv
`default_nettype none
// ============================================================================
// Module      : gpr_dump
// Description : Post-halt register readback. Walks the register file read port
//               and streams each value with its index over valid/ready.
//               Optional macro GPR_DUMP_CHECKSUM_EN appends an XOR checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_dump #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] C_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(LAST_REG);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef GPR_DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CLOAD = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_halt_q;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              w_start;
    logic              w_idx_last;
`ifdef GPR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
`endif

    assign w_start    = halt & ~r_halt_q;
    assign w_idx_last = (r_idx == C_LAST);
    assign rd_addr    = r_idx;
    assign out_data   = r_out_data;
    assign out_index  = r_out_index;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_READ;
            end
            S_READ: begin
                busy        = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
                if (out_ready) w_state_nxt = w_idx_last ? S_CLOAD : S_READ;
`else
                out_last  = w_idx_last;
                if (out_ready) w_state_nxt = w_idx_last ? S_DONE : S_READ;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (!halt) w_state_nxt = S_IDLE;
            end
`ifdef GPR_DUMP_CHECKSUM_EN
            // Checksum word gets its own load cycle so it costs the same as a register word
            S_CLOAD: begin
                busy        = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) w_state_nxt = S_DONE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halt_q    <= 1'b0;
            r_idx       <= C_FIRST;
            r_out_data  <= '0;
            r_out_index <= '0;
`ifdef GPR_DUMP_CHECKSUM_EN
            r_acc       <= '0;
`endif
        end else begin
            r_halt_q <= halt;
            if (r_state == S_IDLE && w_start) begin
                r_idx <= C_FIRST;
`ifdef GPR_DUMP_CHECKSUM_EN
                r_acc <= '0;
`endif
            end
            if (r_state == S_READ) begin
                r_out_data  <= rd_data;
                r_out_index <= r_idx;
`ifdef GPR_DUMP_CHECKSUM_EN
                r_acc       <= r_acc ^ rd_data;
`endif
            end
            // Index parks at the last register; the next start reloads it
            if (r_state == S_SEND && out_ready && !w_idx_last) begin
                r_idx <= r_idx + 1'b1;
            end
`ifdef GPR_DUMP_CHECKSUM_EN
            if (r_state == S_CLOAD) begin
                r_out_data  <= r_acc;
                r_out_index <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_dump
// Description : Self-checking bench for gpr_dump: table of dump scenarios with
//               a word scoreboard, plus a mid-dump reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_dump;

    localparam int FIRST = 1;
    localparam int LAST  = 31;
`ifdef GPR_DUMP_CHECKSUM_EN
    localparam bit CSUM  = 1'b1;
    localparam int BASE  = 64;
`else
    localparam bit CSUM  = 1'b0;
    localparam int BASE  = 62;
`endif

    logic        clock;
    logic        reset;
    logic        halt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] gpr [32];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } word_t;

    typedef struct {
        int          stall_idx;
        int          stall_len;
        int          drop_idx;
        logic [31:0] g1;
        int          exp_cycles;
    } vec_t;

    word_t q[$];
    vec_t  vecs[5];
    int    n_checks;
    int    n_fail;

    gpr_dump dut (
        .clock     (clock),
        .reset     (reset),
        .halt      (halt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data = gpr[rd_addr];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the word on the bus against the scoreboard head; pop only when accepted
    task automatic sb_check(input logic rdy);
        word_t w;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: unexpected word index %0d data 0x%08h", out_index, out_data);
        end else begin
            w = q[0];
            check("word_data", out_data, w.d);
            check("word_index", 32'(out_index), 32'(w.i));
            check("word_last", 32'(out_last), 32'(w.l));
            if (rdy) void'(q.pop_front());
        end
    endtask

    task automatic run_dump(input vec_t v);
        int          n;
        int          stalls;
        logic [31:0] x;
        logic        rdy;
        gpr[1] = v.g1;
        q.delete();
        x = 32'd0;
        for (int i = FIRST; i <= LAST; i++) begin
            q.push_back('{gpr[i], 5'(i), logic'((i == LAST) && !CSUM)});
            x ^= gpr[i];
        end
        if (CSUM) q.push_back('{x, 5'd0, 1'b1});
        halt      = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("busy_read", 32'(busy), 32'd1);
        check("valid_read", 32'(out_valid), 32'd0);
        n      = 0;
        stalls = 0;
        while (!done && n < 300) begin
            rdy = 1'b1;
            if (out_valid && int'(out_index) == v.stall_idx && stalls < v.stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            if (out_valid && int'(out_index) == v.drop_idx) halt = 1'b0;
            out_ready = rdy;
            if (out_valid) sb_check(rdy);
            @(posedge clock); #1;
            n++;
        end
        check("dump_cycles", 32'(n), 32'(v.exp_cycles));
        check("sb_empty", 32'(q.size()), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        if (halt) begin
            repeat (2) begin
                @(posedge clock); #1;
                check("done_held", 32'(done), 32'd1);
            end
            halt = 1'b0;
        end
        @(posedge clock); #1;
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'(FIRST));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) gpr[i] = 32'(i);
        vecs[0] = '{-1, 0, -1, 32'd1,    BASE};
        vecs[1] = '{ 5, 3, -1, 32'd1,    BASE + 3};
        vecs[2] = '{-1, 0, 20, 32'd1,    BASE};
        vecs[3] = '{31, 2, -1, 32'd1,    BASE + 2};
        vecs[4] = '{ 1, 1, -1, 32'h0AA,  BASE + 1};

        reset     = 1'b0;
        halt      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < 5; k++) run_dump(vecs[k]);

        // Reset while index 10 is on the bus, then restart from the first register
        gpr[1]    = 32'd1;
        halt      = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_index == 5'd10) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("reach_idx10", 32'(out_index), 32'd10);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals();
        halt = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals();
        run_dump(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
